// File: rtl/timestamp_capture_if.sv
// timestamp_capture_if: host-side read handshake and status of the timestamp FIFO
interface timestamp_capture_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     clear_overflow;
    modport master (output out_valid, out_data, level, overflow, input out_ready, clear_overflow);
    modport slave  (input out_valid, out_data, level, overflow, output out_ready, clear_overflow);
endinterface

// File: rtl/timestamp_capture.sv
// timestamp_capture: synchronise an async event, capture the cycle count on each rising edge into a show-ahead FIFO
module timestamp_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   count,
    input  logic               event_in,
    timestamp_capture_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic             s1, s2, s3;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             edge_det, full, rd, wr, drop;
    assign edge_det = s2 & ~s3;
    assign full     = level == LW'(DEPTH);
    assign rd       = bus.out_valid & bus.out_ready;
    // a read in the same cycle frees the slot, so a full FIFO still accepts the edge
    assign wr       = edge_det & (~full | rd);
    assign drop     = edge_det & full & ~rd;
    assign bus.out_valid = level != '0;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.level     = level;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            s3           <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            s1     <= event_in;
            s2     <= s1;
            s3     <= s2;
            wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + LW'(wr) - LW'(rd);
            bus.overflow <= drop ? 1'b1 : bus.clear_overflow ? 1'b0 : bus.overflow;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= count;
    end
endmodule

// File: tb/tb_timestamp_capture.sv
// tb_timestamp_capture: directed scenarios with hand-computed timestamps
module tb_timestamp_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        event_in = 1'b1;
    logic [31:0] cyc = 32'd0;
    logic [31:0] cnt_off = 32'd0;
    logic [31:0] count;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign count = cyc + cnt_off;

    timestamp_capture_if #(.WIDTH(32), .DEPTH(4)) bus ();
    timestamp_capture #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .count(count), .event_in(event_in), .bus(bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // count equals v at the next rising edge, v+k k edges later
    task automatic set_count(input logic [31:0] v);
        cnt_off = v - cyc;
    endtask

    task automatic pulse();
        event_in = 1'b1;
        tick(3);
        event_in = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if ({bus.out_valid, bus.level, bus.overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b level=%0d ovf=%b, want 0/0/0", bus.out_valid, bus.level, bus.overflow);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_checks++;
            if ({bus.out_valid, bus.level, bus.overflow} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_high_%0d: valid=%b level=%0d ovf=%b, want 0/0/0", i, bus.out_valid, bus.level, bus.overflow);
            end
        end
    endtask

    task automatic test_single_capture();
        event_in = 1'b0;
        tick(3);
        set_count(32'h64);
        event_in = 1'b1;
        tick(2);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: valid=%b want 0", bus.out_valid);
        end
        tick(1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h66 || bus.level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_capture: valid=%b data=%h level=%0d, want 1/66/1", bus.out_valid, bus.out_data, bus.level);
        end
        event_in = 1'b0;
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
            n_fail++;
            $display("FAIL single_read: valid=%b level=%0d, want 0/0", bus.out_valid, bus.level);
        end
        tick(2);
    endtask

    task automatic test_fill_overflow();
        logic [31:0] exp_q [4] = '{32'd12, 32'd18, 32'd24, 32'd30};
        set_count(32'd10);
        repeat (5) pulse();
        n_checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_status: level=%0d ovf=%b, want 4/1", bus.level, bus.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fill_drain_%0d: valid=%b data=%0d, want 1/%0d", i, bus.out_valid, bus.out_data, exp_q[i]);
            end
            bus.out_ready = 1'b1;
            tick(1);
            bus.out_ready = 1'b0;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_fifth_absent: valid=%b want 0", bus.out_valid);
        end
        bus.clear_overflow = 1'b1;
        tick(1);
        bus.clear_overflow = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_clear: ovf=%b want 0", bus.overflow);
        end
    endtask

    task automatic test_full_concurrent_read();
        logic [31:0] exp_q [4] = '{32'd108, 32'd114, 32'd120, 32'd202};
        set_count(32'd100);
        repeat (4) pulse();
        set_count(32'd200);
        event_in = 1'b1;
        tick(2);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        event_in = 1'b0;
        n_checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw_status: level=%0d ovf=%b, want 4/0", bus.level, bus.overflow);
        end
        tick(3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_rw_drain_%0d: valid=%b data=%0d, want 1/%0d", i, bus.out_valid, bus.out_data, exp_q[i]);
            end
            bus.out_ready = 1'b1;
            tick(1);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_held_and_clear_race();
        set_count(32'd300);
        event_in = 1'b1;
        tick(10);
        event_in = 1'b0;
        tick(3);
        n_checks++;
        if (bus.level !== 3'd1 || bus.out_data !== 32'd302) begin
            n_fail++;
            $display("FAIL held_once: level=%0d data=%0d, want 1/302", bus.level, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        set_count(32'd400);
        repeat (4) pulse();
        n_checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL race_prefill: level=%0d ovf=%b, want 4/0", bus.level, bus.overflow);
        end
        event_in = 1'b1;
        tick(2);
        bus.clear_overflow = 1'b1;
        tick(1);
        bus.clear_overflow = 1'b0;
        event_in = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.level !== 3'd4) begin
            n_fail++;
            $display("FAIL race_set_wins: ovf=%b level=%0d, want 1/4", bus.overflow, bus.level);
        end
        tick(2);
        bus.clear_overflow = 1'b1;
        tick(1);
        bus.clear_overflow = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL race_clear_alone: ovf=%b want 0", bus.overflow);
        end
    endtask

    task automatic test_reset_mid_operation();
        pulse();
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.level !== 3'd3 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: level=%0d ovf=%b, want 3/1", bus.level, bus.overflow);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.level, bus.overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset: valid=%b level=%0d ovf=%b, want 0/0/0", bus.out_valid, bus.level, bus.overflow);
        end
        tick(1);
        reset = 1'b1;
        tick(3);
        set_count(32'd500);
        pulse();
        n_checks++;
        if (bus.level !== 3'd1 || bus.out_data !== 32'd502 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_recapture: level=%0d data=%0d ovf=%b, want 1/502/0", bus.level, bus.out_data, bus.overflow);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.clear_overflow = 1'b0;
        test_reset();
        test_single_capture();
        test_fill_overflow();
        test_full_concurrent_read();
        test_held_and_clear_race();
        test_reset_mid_operation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
